// File: rtl/op_mult_pkg.sv
// Shared types for the sequential multiplier family.
// FSM states, latched mode bundle, and narrowing limits (valid for N <= 32).
package op_mult_pkg;

  localparam int LIM_W = 72;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } op_mult_state_e;

  typedef struct packed {
    logic is_signed;
    logic sat;
  } op_mult_mode_t;

  typedef struct packed {
    logic signed [LIM_W-1:0] lo;
    logic signed [LIM_W-1:0] hi;
  } op_mult_lim_t;

  // Representable range of an m-bit result.
  function automatic op_mult_lim_t sat_limits(
    input int   m,
    input logic is_signed
  );
    op_mult_lim_t            l;
    logic signed [LIM_W-1:0] one;
    one = LIM_W'(1);
    if (is_signed) begin
      l.hi = (one <<< (m - 1)) - one;
      l.lo = -(one <<< (m - 1));
    end else begin
      l.hi = (one <<< m) - one;
      l.lo = '0;
    end
    return l;
  endfunction

endpackage

// File: rtl/op_mult_narrow.sv
// Combinational scale/narrow of a 2N-bit product: shift by SHIFT, fit check, saturate/wrap.
// Ports: p_i, is_signed_i, sat_i -> result_o, ov_o. Macro OP_MULT_SEQ_ROUND_EN: round half up.
module op_mult_narrow
  import op_mult_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = N,
  parameter int SHIFT = 0
) (
  input  logic [2*N-1:0] p_i,
  input  logic           is_signed_i,
  input  logic           sat_i,
  output logic [M-1:0]   result_o,
  output logic           ov_o
);

  // Two guard bits keep an unsigned product plus rounding bias
  // non-negative in the signed domain.
  localparam int XW = 2*N + 2;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [XW-1:0] RND =
    (SHIFT > 0) ? (XW'(1) << RS) : '0;

  logic signed [XW-1:0]    px;
  logic signed [XW-1:0]    qx;
  logic signed [LIM_W-1:0] qe;
  logic [LIM_W-1:0]        satv;
  op_mult_lim_t            lim;

  always_comb begin
    if (is_signed_i) begin
      px = {{2{p_i[2*N-1]}}, p_i};
    end else begin
      px = {2'b00, p_i};
    end
`ifdef OP_MULT_SEQ_ROUND_EN
    px = px + RND;
`endif
    qx   = px >>> SHIFT;
    qe   = {{(LIM_W-XW){qx[XW-1]}}, qx};
    lim  = sat_limits(M, is_signed_i);
    ov_o = (qe > $signed(lim.hi)) ||
           (qe < $signed(lim.lo));
    satv = qe[LIM_W-1] ? lim.lo : lim.hi;
    if (ov_o && sat_i) begin
      result_o = satv[M-1:0];
    end else begin
      result_o = qe[M-1:0];
    end
  end

`ifndef OP_MULT_SEQ_ROUND_EN
  logic unused_rnd;
  assign unused_rnd = ^RND;
`endif

endmodule

// File: rtl/op_mult_seq.sv
// Iterative shift-add N x N multiplier, one partial product per cycle, valid/ready on both sides.
// Ports: clk, rst_n, in_valid_i/in_ready_o, a_i, b_i, signed_mode_i, saturate_i,
// out_valid_o/out_ready_i, result_o, ov_o, busy_o. Macro OP_MULT_SEQ_ROUND_EN (via op_mult_narrow).
module op_mult_seq
  import op_mult_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = N,
  parameter int SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         signed_mode_i,
  input  logic         saturate_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [M-1:0] result_o,
  output logic         ov_o,
  output logic         busy_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  op_mult_state_e state_q;
  op_mult_mode_t  mode_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   mag_a_q;
  logic [N-1:0]   mag_b_q;
  logic           sign_q;
  logic [2*N-1:0] acc_q;
  logic [M-1:0]   result_q;
  logic           ov_q;
  logic           out_valid_q;

  logic [N-1:0]   mag_a_d;
  logic [N-1:0]   mag_b_d;
  logic [2*N-1:0] pp;
  logic [2*N-1:0] acc_d;
  logic [2*N-1:0] prod;
  logic [M-1:0]   nar_res;
  logic           nar_ov;

  // Magnitudes fit in N unsigned bits, including |-2^(N-1)|.
  always_comb begin
    mag_a_d = a_i;
    mag_b_d = b_i;
    if (signed_mode_i && a_i[N-1]) begin
      mag_a_d = ~a_i + N'(1);
    end
    if (signed_mode_i && b_i[N-1]) begin
      mag_b_d = ~b_i + N'(1);
    end
  end

  // The last partial product is folded in combinationally so the
  // narrowed result can be registered on the final CALC edge.
  always_comb begin
    pp = '0;
    if (mag_b_q[cnt_q]) begin
      pp = {{N{1'b0}}, mag_a_q} << cnt_q;
    end
    acc_d = acc_q + pp;
    prod  = sign_q ? (~acc_d + (2*N)'(1)) : acc_d;
  end

  op_mult_narrow #(
    .N     (N),
    .M     (M),
    .SHIFT (SHIFT)
  ) u_narrow (
    .p_i         (prod),
    .is_signed_i (mode_q.is_signed),
    .sat_i       (mode_q.sat),
    .result_o    (nar_res),
    .ov_o        (nar_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q          <= CALC;
            mode_q.is_signed <= signed_mode_i;
            mode_q.sat       <= saturate_i;
            mag_a_q          <= mag_a_d;
            mag_b_q          <= mag_b_d;
            sign_q           <= signed_mode_i &
                                (a_i[N-1] ^ b_i[N-1]);
            cnt_q            <= '0;
            acc_q            <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            result_q    <= nar_res;
            ov_q        <= nar_ov;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign ov_o        = ov_q;

endmodule
